// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - size mask encodings used on req_rden / req_wren
//   - FSM state encoding
//   - machine timer (mtime) addresses, used when DMEM_MTIME_EN is defined
//   - latched request record and a mask legality helper
package dmem_responder_pkg;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  localparam logic [31:0] MTIME_LO_ADDR = 32'h0200_BFF8;
  localparam logic [31:0] MTIME_HI_ADDR = 32'h0200_BFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rden;
    logic        sext;
    logic [3:0]  wren;
    logic [31:0] wdata;
  } req_t;

  function automatic logic mask_legal(input logic [3:0] m);
    return (m == MASK_NONE) || (m == MASK_B) || (m == MASK_H) || (m == MASK_W);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for one byte/half/word access (combinational).
// Ports:
//   size     in  4  : access size mask (MASK_B / MASK_H / MASK_W)
//   offset   in  2  : addr[1:0]
//   sext     in  1  : sign-extend read data (ignored for words)
//   wr_data  in  32 : right-justified store data
//   rd_word  in  32 : raw RAM word
//   strb     out 4  : byte write strobes (size shifted by offset)
//   wr_word  out 32 : store data moved onto its byte lanes
//   rd_data  out 32 : read bytes shifted down to bit 0 and extended
//   misalign out 1  : half on odd address or word not on a word boundary
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [3:0]  size,
  input  logic [1:0]  offset,
  input  logic        sext,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  strb,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    strb     = size << offset;
    wr_word  = wr_data << {offset, 3'b000};
    shifted  = rd_word >> {offset, 3'b000};
    misalign = 1'b0;
    rd_data  = '0;
    case (size)
      MASK_B: rd_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      MASK_H: begin
        rd_data  = {{16{sext & shifted[15]}}, shifted[15:0]};
        misalign = offset[0];
      end
      MASK_W: begin
        rd_data  = shifted;
        misalign = (offset != 2'b00);
      end
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it on an
// internal word-organised RAM after WAIT_CYCLES wait states and returns a
// one-cycle response with extended read data or an error flag.
// Optional feature macro: DMEM_MTIME_EN adds a 64-bit mtime counter mapped at
// 0x0200_BFF8 (low) / 0x0200_BFFC (high), word access only.
// Parameters: ADDR_WIDTH (word-address bits, <= 29), WAIT_CYCLES (0..15).
// Ports:
//   clk, rst (sync, active high)
//   req_vld/req_rdy handshake; req_addr, req_rden, req_rden_sext, req_wren,
//   req_wrdata request fields
//   rsp_vld pulse with rsp_rdata / rsp_err (zero outside the pulse)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_rden,
  input  logic        req_rden_sext,
  input  logic [3:0]  req_wren,
  input  logic [31:0] req_wrdata,
  output logic        rsp_vld,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  req_t        req_q;
  req_t        req_in;
  req_t        act;
  logic [31:0] mem [2**ADDR_WIDTH];

  logic [3:0]            size;
  logic                  is_read, is_write, access;
  logic                  err, enter_resp, ram_write, timer_write;
  logic                  is_timer;
  logic [31:0]           timer_rdata;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           ram_word, rd_value;
  logic [3:0]            strb;
  logic [31:0]           wr_word, rd_aligned;
  logic                  misalign;

  assign req_in = '{addr: req_addr, rden: req_rden, sext: req_rden_sext,
                    wren: req_wren, wdata: req_wrdata};

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the live request fields are used in IDLE and the latched copy later.
  assign act = (state == ST_IDLE) ? req_in : req_q;

  assign req_rdy = (state == ST_IDLE) && !rst;

  assign enter_resp = !rst &&
    (((state == ST_IDLE) && req_vld && (WAIT_CYCLES == 0)) ||
     ((state == ST_WAIT) && (cnt == 4'd0)));

  assign widx     = act.addr[ADDR_WIDTH+1:2];
  assign ram_word = mem[widx];

  dmem_lane_align u_align (
    .size     (size),
    .offset   (act.addr[1:0]),
    .sext     (act.sext),
    .wr_data  (act.wdata),
    .rd_word  (ram_word),
    .strb     (strb),
    .wr_word  (wr_word),
    .rd_data  (rd_aligned),
    .misalign (misalign)
  );

`ifdef DMEM_MTIME_EN
  logic [63:0] mtime;
  logic [63:0] mtime_inc;

  assign is_timer    = (act.addr[31:3] == MTIME_LO_ADDR[31:3]);
  assign mtime_inc   = mtime + 64'd1;
  assign timer_rdata = act.addr[2] ? mtime[63:32] : mtime[31:0];

  // A write loads one half; the other half still advances as part of the
  // 64-bit count (carry from the pre-write low half included).
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (timer_write) begin
      if (act.addr[2] == MTIME_HI_ADDR[2]) mtime <= {act.wdata, mtime_inc[31:0]};
      else                                 mtime <= {mtime_inc[63:32], act.wdata};
    end else begin
      mtime <= mtime_inc;
    end
  end
`else
  assign is_timer    = 1'b0;
  assign timer_rdata = '0;
`endif

  always_comb begin
    size     = (act.rden != MASK_NONE) ? act.rden : act.wren;
    is_read  = (act.rden != MASK_NONE);
    is_write = (act.wren != MASK_NONE) && !is_read;
    access   = is_read || (act.wren != MASK_NONE);
    err      = 1'b0;
    if (is_read && (act.wren != MASK_NONE))          err = 1'b1;
    if (!mask_legal(act.rden) || !mask_legal(act.wren)) err = 1'b1;
    if (access && misalign)                          err = 1'b1;
    if (access && is_timer && (size != MASK_W))      err = 1'b1;
    if (access && !is_timer && (act.addr[31:ADDR_WIDTH+2] != '0)) err = 1'b1;
    ram_write   = enter_resp && is_write && !err && !is_timer;
    timer_write = enter_resp && is_write && !err && is_timer;
    rd_value    = '0;
    if (is_read && !err) rd_value = is_timer ? timer_rdata : rd_aligned;
  end

  // RAM has no reset; only strobed byte lanes are written.
  always_ff @(posedge clk) begin
    if (ram_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (strb[i]) mem[widx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_vld) begin
            req_q <= req_in;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        rsp_vld   <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (ADDR_WIDTH=12, WAIT_CYCLES=1).
module tb_dmem_responder;

  localparam int unsigned AW = 12;
  localparam int unsigned WC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic [3:0]  req_rden;
  logic        req_rden_sext;
  logic [3:0]  req_wren;
  logic [31:0] req_wrdata;
  logic        rsp_vld;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_addr      (req_addr),
    .req_rden      (req_rden),
    .req_rden_sext (req_rden_sext),
    .req_wren      (req_wren),
    .req_wrdata    (req_wrdata),
    .rsp_vld       (rsp_vld),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned acc_cyc[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response pops one expectation (data, error, cycle).
  always @(negedge clk) begin
    exp_t e;
    if (rsp_vld && !rst) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b at cyc %0d, want no response",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.cyc) begin
          n_miss++;
          $display("FAIL %s: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                   e.name, rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Present a request (req_vld left high) and wait for its accept edge.
  task automatic issue(input string name, input logic [31:0] addr, input logic [3:0] rden,
                       input logic sext, input logic [3:0] wren, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit expect_rsp);
    int unsigned guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    req_vld       = 1'b1;
    req_addr      = addr;
    req_rden      = rden;
    req_rden_sext = sext;
    req_wren      = wren;
    req_wrdata    = wdata;
    while (!req_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_rdy) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s accept_timeout: got req_rdy=0, want 1 within 100 cycles", name);
    end else begin
      if (expect_rsp) begin
        e.name  = name;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + 1 + WC;
        exp_q.push_back(e);
      end
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    req_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned a0, a1, a2, guard;
    rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_rden = '0;
    req_rden_sext = 1'b0; req_wren = '0; req_wrdata = '0;
    repeat (3) @(negedge clk);
    chk("rdy_in_reset", {31'b0, req_rdy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_reset", {31'b0, req_rdy}, 32'd1);
    chk("vld_after_reset", {31'b0, rsp_vld}, 32'd0);
    chk("rdata_after_reset", rsp_rdata, 32'd0);
    chk("err_after_reset", {31'b0, rsp_err}, 32'd0);

    // Basic word store/load, byte lanes and sign extension
    issue("sw_10",      32'h10, 4'h0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1);
    issue("lw_10",      32'h10, 4'hF, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1);
    issue("sb_13",      32'h13, 4'h0, 1'b0, 4'h1, 32'h00000080, 32'h0,        1'b0, 1);
    issue("lb_13_sext", 32'h13, 4'h1, 1'b1, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0, 1);
    issue("lbu_13",     32'h13, 4'h1, 1'b0, 4'h0, 32'h0,        32'h00000080, 1'b0, 1);
    issue("lw_10_b",    32'h10, 4'hF, 1'b0, 4'h0, 32'h0,        32'h80ADBEEF, 1'b0, 1);
    issue("lh_12_sext", 32'h12, 4'h3, 1'b1, 4'h0, 32'h0,        32'hFFFF80AD, 1'b0, 1);
    issue("lhu_10",     32'h10, 4'h3, 1'b0, 4'h0, 32'h0,        32'h0000BEEF, 1'b0, 1);
    issue("lb_10_sext", 32'h10, 4'h1, 1'b1, 4'h0, 32'h0,        32'hFFFFFFEF, 1'b0, 1);

    // Error cases and no-op
    issue("lh_11_mis",  32'h11, 4'h3, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1);
    issue("sw_12_mis",  32'h12, 4'h0, 1'b0, 4'hF, 32'h11111111, 32'h0,        1'b1, 1);
    issue("lw_10_c",    32'h10, 4'hF, 1'b0, 4'h0, 32'h0,        32'h80ADBEEF, 1'b0, 1);
    issue("both_masks", 32'h10, 4'hF, 1'b0, 4'hF, 32'h22222222, 32'h0,        1'b1, 1);
    issue("bad_mask",   32'h10, 4'h7, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1);
    issue("out_range",  32'h4000, 4'hF, 1'b0, 4'h0, 32'h0,      32'h0,        1'b1, 1);
    issue("noop",       32'h10, 4'h0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1);
    issue("sh_12",      32'h12, 4'h0, 1'b0, 4'h3, 32'h00001234, 32'h0,        1'b0, 1);
    issue("lw_10_sext", 32'h10, 4'hF, 1'b1, 4'h0, 32'h0,        32'h1234BEEF, 1'b0, 1);
    idle(4);

    // Back-to-back with req_vld held: accepts 3 cycles apart
    acc_cyc.delete();
    issue("b2b_0", 32'h20, 4'h0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1);
    issue("b2b_1", 32'h20, 4'hF, 1'b0, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0, 1);
    issue("b2b_2", 32'h10, 4'hF, 1'b0, 4'h0, 32'h0,        32'h1234BEEF, 1'b0, 1);
    idle(4);
    if (acc_cyc.size() == 3) begin
      a0 = acc_cyc[0]; a1 = acc_cyc[1]; a2 = acc_cyc[2];
      chk("b2b_gap_01", a1 - a0, WC + 2);
      chk("b2b_gap_12", a2 - a1, WC + 2);
    end else begin
      n_vec++; n_miss++;
      $display("FAIL b2b_accepts: got %0d accepts, want 3", acc_cyc.size());
    end

    // Reset while the store waits: no response, no write
    issue("sw_20_rst", 32'h20, 4'h0, 1'b0, 4'hF, 32'h12345678, 32'h0, 1'b0, 0);
    req_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rdy_in_wait_reset", {31'b0, req_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_after_wait_reset", {31'b0, req_rdy}, 32'd1);
    chk("vld_after_wait_reset", {31'b0, rsp_vld}, 32'd0);
    issue("lw_20_old", 32'h20, 4'hF, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1);
    idle(4);

    // Machine timer
`ifdef DMEM_MTIME_EN
    issue("mtime_lo_wr", 32'h0200BFF8, 4'h0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0, 1);
    issue("mtime_hi_rd", 32'h0200BFFC, 4'hF, 1'b0, 4'h0, 32'h0,        32'h00000001, 1'b0, 1);
    issue("mtime_half",  32'h0200BFF8, 4'h3, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1);
`else
    issue("mtime_lo_wr", 32'h0200BFF8, 4'h0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    issue("mtime_hi_rd", 32'h0200BFFC, 4'hF, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1);
`endif
    idle(4);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL rsp_timeout: got %0d responses outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the core's load/store port: accepts one byte/half/word request at a time from the memory-access stage, performs it against an internal word-organised RAM after a fixed number of wait states, and returns extended read data or an error. Bridges the core's `rden`/`wren` lane masks and sign-extend flag to physical memory. Optionally hosts a 64-bit machine timer.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 1: wait states per access, legal range 0..15.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_vld` in 1: request present.
- `req_rdy` out 1: responder accepts a request this cycle.
- `req_addr` in 32: byte address.
- `req_rden` in 4: read size mask, 4'b0001 byte, 4'b0011 half, 4'b1111 word, 0 none.
- `req_rden_sext` in 1: sign-extend read data; ignored for word reads.
- `req_wren` in 4: write size mask, same encoding as `req_rden`.
- `req_wrdata` in 32: store data, right-justified.
- `rsp_vld` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: right-justified, zero- or sign-extended read data.
- `rsp_err` out 1: request rejected; valid with `rsp_vld`.

## Operation
- FSM states: IDLE, WAIT, RESP. `req_rdy` = 1 only in IDLE.
- IDLE: on `req_vld`, latch all request fields. Go to WAIT when WAIT_CYCLES > 0 (load counter with WAIT_CYCLES-1), otherwise go to RESP.
- WAIT: decrement the counter. At 0, go to RESP.
- RESP: `rsp_vld` = 1 for one cycle, then return to IDLE.
- Lane shift: the mask is shifted left by `addr[1:0]`. Write strobes merge only the selected bytes. Read bytes are shifted down to bit 0, then extended.
- Error cases (`rsp_err` = 1, no write, `rsp_rdata` = 0):
  - both masks nonzero;
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` != 0;
  - illegal mask value;
  - `addr[31:ADDR_WIDTH+2]` nonzero and not a timer address.
- Both masks zero: no-op. Still responds, with `rsp_err` = 0 and `rsp_rdata` = 0.
- RAM contents are not cleared by reset.

## Timing
- Accept in cycle T (`req_vld & req_rdy`). `rsp_vld` is asserted in cycle T+1+WAIT_CYCLES.
- `req_rdy` is low from T+1 through the RESP cycle. Throughput is one request per WAIT_CYCLES+2 cycles.
- A write commits on the clock edge that enters RESP. A read accepted afterwards returns the new data.
- RAM read is synchronous, issued on the edge entering RESP. `rsp_rdata`/`rsp_err` are registered and stable only during `rsp_vld`; they are 0 otherwise.
- Reset values: state IDLE, `req_rdy` = 0 during reset and 1 in the first cycle after, `rsp_vld` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter 0.
- Reset asserted in WAIT: the pending write is discarded and no response is issued. Reset in RESP: the pulse is cut and any already-committed write stays.
- Request inputs outside IDLE are ignored. The requester holds them until accepted.

## Configuration
- `DMEM_MTIME_EN` defined:
  - 64-bit `mtime` counter, reset to 0, increments every cycle.
  - Mapped at 0x0200_BFF8 (low word) and 0x0200_BFFC (high word). Word access only; non-word access is an error.
  - A write loads the addressed half; that cycle's increment is suppressed for the loaded half.
  - A read returns the value sampled on the edge entering RESP.
- `DMEM_MTIME_EN` undefined: those addresses are out of range and give `rsp_err`.

## Structure
- Shared defines file holds:
  - size mask encodings (`MASK_B`/`MASK_H`/`MASK_W`);
  - FSM state encodings;
  - MTIME base addresses.
- Sub-module `dmem_lane_align` (combinational): takes size, `addr[1:0]`, sext flag and data; produces byte strobes, merged write word, aligned read word and the misalignment flag.
- Top holds the FSM, wait counter, RAM array, request latch and optional timer.

## Test plan
- WAIT_CYCLES = 1. Store word 0xDEADBEEF at 0x10, then load word 0x10 → `rsp_vld` 2 cycles after each accept, `rdata` = 0xDEADBEEF, `err` = 0.
- Store byte 0x80 at 0x13, then load byte 0x13 with sext → 0xFFFFFF80. Without sext → 0x00000080. Load word 0x10 → 0x80ADBEEF.
- Load half at 0x11 → `err` = 1, `rdata` = 0. Store word at 0x12 → `err` = 1 and word 0x10 unchanged.
- Back-to-back requests with `req_vld` held high → `req_rdy` pulses every 3 cycles. Second request accepted exactly 1 cycle after the first `rsp_vld`.
- Reset asserted in WAIT during a store of 0x12345678 to 0x20 → no `rsp_vld`, and a later load of 0x20 returns the old value.
- `DMEM_MTIME_EN`: write 0xFFFFFFFF to the low word, then read the high word 3 cycles later → 0x00000001. Without the macro, the same write → `err` = 1.
